mem_access_unit: RTL and testbench

- Memory-stage load/store unit placed between the EX/MEM pipeline register and an external word-wide data bus with an acknowledge handshake.
- Takes the effective address, store data and funct3 access type. Produces byte enables and aligned write data, and returns sign- or zero-extended load data to the MEM/WB register.
- Holds the pipeline through a stall output until the bus transaction completes, is rejected as misaligned, or times out.

---
 rtl/mem_access_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns an EX/MEM access into a word-wide bus
// transaction with byte enables, extends load data, and stalls the pipeline
// until the access completes, faults as misaligned, or times out.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] load_data,
   output logic        fault_misaligned,
   output logic        fault_bus,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      type_q, type_d;
   logic [1:0]      off_q, off_d;
   logic            bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic [31:0]     bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic [3:0]      bus_be_q, bus_be_d;
   logic            resp_valid_q, resp_valid_d, fm_q, fm_d, fb_q, fb_d;
   logic [31:0]     load_data_q, load_data_d;

   logic            misaligned;
   logic [3:0]      req_be;
   logic [31:0]     req_wdata_rep;
   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;
   logic [31:0]     rd_ext;

   // Alignment / legality check of the incoming request.
   always_comb begin
      misaligned = 1'b0;
      case (req_type)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = req_addr[0];
         3'b010:         misaligned = (req_addr[1:0] != 2'b00);
         default:        misaligned = 1'b1;
      endcase
   end

   // Byte enables and lane-replicated store data for the incoming request.
   always_comb begin
      req_be        = 4'b1111;
      req_wdata_rep = req_wdata;
      case (req_type[1:0])
         2'b00: begin
            req_be        = 4'b0001 << req_addr[1:0];
            req_wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
            req_wdata_rep = {2{req_wdata[15:0]}};
         end
         default: begin
            req_be        = 4'b1111;
            req_wdata_rep = req_wdata;
         end
      endcase
   end

   // Lane select and extension of the returned bus word by latched type/offset.
   always_comb begin
      rd_byte = bus_rdata[{off_q, 3'b000} +: 8];
      rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (type_q)
         3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  rd_ext = {24'h0, rd_byte};
         3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
         3'b101:  rd_ext = {16'h0, rd_half};
         default: rd_ext = bus_rdata;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      type_d       = type_q;
      off_d        = off_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_be_d     = bus_be_q;
      bus_wdata_d  = bus_wdata_q;
      resp_valid_d = 1'b0;
      fm_d         = fm_q;
      fb_d         = fb_q;
      load_data_d  = load_data_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (misaligned) begin
                  state_d      = StDone;
                  fm_d         = 1'b1;
                  resp_valid_d = 1'b1;
               end else begin
                  state_d     = StBusy;
                  cnt_d       = '0;
                  type_d      = req_type;
                  off_d       = req_addr[1:0];
                  bus_req_d   = 1'b1;
                  bus_we_d    = req_write;
                  bus_addr_d  = {req_addr[31:2], 2'b00};
                  bus_be_d    = req_be;
                  bus_wdata_d = req_wdata_rep;
               end
            end
         end
         StBusy: begin
            if (bus_ack) begin
               state_d      = StDone;
               bus_req_d    = 1'b0;
               bus_we_d     = 1'b0;
               resp_valid_d = 1'b1;
               load_data_d  = bus_we_q ? 32'h0 : rd_ext;
            end else if ((TIMEOUT_CYCLES != 0) &&
                         ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES)) begin
               state_d      = StDone;
               bus_req_d    = 1'b0;
               bus_we_d     = 1'b0;
               resp_valid_d = 1'b1;
               fb_d         = 1'b1;
               load_data_d  = 32'h0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d     = StIdle;
            fm_d        = 1'b0;
            fb_d        = 1'b0;
            load_data_d = 32'h0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         type_q       <= 3'b000;
         off_q        <= 2'b00;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= 32'h0;
         bus_be_q     <= 4'h0;
         bus_wdata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         fm_q         <= 1'b0;
         fb_q         <= 1'b0;
         load_data_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         type_q       <= type_d;
         off_q        <= off_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_be_q     <= bus_be_d;
         bus_wdata_q  <= bus_wdata_d;
         resp_valid_q <= resp_valid_d;
         fm_q         <= fm_d;
         fb_q         <= fb_d;
         load_data_q  <= load_data_d;
      end
   end

   // Stall drops during reset so the pipeline is released immediately.
   assign stall            = req_valid & ~resp_valid_q & RESET;
   assign resp_valid       = resp_valid_q;
   assign load_data        = load_data_q;
   assign fault_misaligned = fm_q;
   assign fault_bus        = fb_q;
   assign bus_req          = bus_req_q;
   assign bus_we           = bus_we_q;
   assign bus_addr         = bus_addr_q;
   assign bus_be           = bus_be_q;
   assign bus_wdata        = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses are queued when a
// request is driven and compared when resp_valid pulses.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_type = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        stall, resp_valid, fault_misaligned, fault_bus;
   logic [31:0] load_data;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   typedef struct packed {
      logic [31:0] ld;
      logic        fm;
      logic        fb;
   } resp_t;

   resp_t sb_q[$];
   int    n_checks = 0;
   int    n_bad = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .req_valid        (req_valid),
      .req_write        (req_write),
      .req_type         (req_type),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .stall            (stall),
      .resp_valid       (resp_valid),
      .load_data        (load_data),
      .fault_misaligned (fault_misaligned),
      .fault_bus        (fault_bus),
      .bus_req          (bus_req),
      .bus_we           (bus_we),
      .bus_addr         (bus_addr),
      .bus_be           (bus_be),
      .bus_wdata        (bus_wdata),
      .bus_ack          (bus_ack),
      .bus_rdata        (bus_rdata)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Response monitor: pop the oldest expectation on every resp_valid pulse.
   always @(negedge CLK) begin
      if (RESET && resp_valid) begin
         if (sb_q.size() == 0) begin
            check_val("sb_unexpected_resp", 32'd1, 32'd0);
         end else begin
            resp_t e;
            e = sb_q.pop_front();
            check_val("sb_load_data", load_data, e.ld);
            check_val("sb_fault_misaligned", {31'h0, fault_misaligned}, {31'h0, e.fm});
            check_val("sb_fault_bus", {31'h0, fault_bus}, {31'h0, e.fb});
         end
      end
   end

   // One access from IDLE; ack_delay < 0 means never acknowledge.
   task automatic do_access(input logic wr, input logic [2:0] typ, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ack_delay, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_ld,
                            input logic exp_fm, input logic exp_fb,
                            input int exp_resp_cyc, input int exp_req_cycles);
      resp_t e;
      int cyc, stalls, reqs, resp_cyc;
      req_valid = 1'b1;
      req_write = wr;
      req_type  = typ;
      req_addr  = addr;
      req_wdata = wdata;
      bus_rdata = rdata;
      e.ld = exp_ld;
      e.fm = exp_fm;
      e.fb = exp_fb;
      sb_q.push_back(e);
      cyc = 0; stalls = 0; reqs = 0; resp_cyc = -1;
      while (resp_cyc < 0 && cyc < 40) begin
         bus_ack = (ack_delay >= 0) && (cyc == 1 + ack_delay);
         @(negedge CLK);
         if (cyc == 1 && exp_req_cycles > 0) begin
            check_val("bus_we", {31'h0, bus_we}, {31'h0, wr});
            check_val("bus_addr", bus_addr, {addr[31:2], 2'b00});
            check_val("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
            check_val("bus_wdata", bus_wdata, exp_wdata);
         end
         if (stall) stalls++;
         if (bus_req) reqs++;
         if (resp_valid) resp_cyc = cyc;
         @(posedge CLK);
         #1;
         cyc++;
      end
      bus_ack   = 1'b0;
      req_valid = 1'b0;
      check_val("resp_cycle", resp_cyc, exp_resp_cyc);
      check_val("stall_cycles", stalls, exp_resp_cyc);
      check_val("bus_req_cycles", reqs, exp_req_cycles);
      // Cycle after DONE: pulse over, flags and data cleared.
      @(negedge CLK);
      check_val("post_resp_valid", {31'h0, resp_valid}, 32'h0);
      check_val("post_load_data", load_data, 32'h0);
      check_val("post_faults", {30'h0, fault_misaligned, fault_bus}, 32'h0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_val("rst_bus_req", {31'h0, bus_req}, 32'h0);
      check_val("rst_bus_be", {28'h0, bus_be}, 32'h0);
      check_val("rst_load_data", load_data, 32'h0);
      check_val("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      // LB, ack two cycles after bus_req
      do_access(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80AA5511, 2, 4'b1000, 32'h0,
                32'hFFFFFF80, 1'b0, 1'b0, 4, 3);
      // LHU / LH, immediate ack
      do_access(1'b0, 3'b101, 32'h2002, 32'h0, 32'hBEEF1234, 0, 4'b1100, 32'h0,
                32'h0000BEEF, 1'b0, 1'b0, 2, 1);
      do_access(1'b0, 3'b001, 32'h2002, 32'h0, 32'hBEEF1234, 0, 4'b1100, 32'h0,
                32'hFFFFBEEF, 1'b0, 1'b0, 2, 1);
      // LBU lane 1 zero-extended
      do_access(1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000F300, 1, 4'b0010, 32'h0,
                32'h000000F3, 1'b0, 1'b0, 3, 2);
      // SB: replicated byte, store returns zero data
      do_access(1'b1, 3'b000, 32'h3001, 32'h000000A5, 32'hFFFFFFFF, 1, 4'b0010, 32'hA5A5A5A5,
                32'h0, 1'b0, 1'b0, 3, 2);
      // SH upper half
      do_access(1'b1, 3'b001, 32'h3002, 32'h1234ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD,
                32'h0, 1'b0, 1'b0, 2, 1);
      // Misaligned LW and illegal type: no bus activity
      do_access(1'b0, 3'b010, 32'h4002, 32'h0, 32'h0, -1, 4'h0, 32'h0,
                32'h0, 1'b1, 1'b0, 1, 0);
      do_access(1'b0, 3'b011, 32'h4000, 32'h0, 32'h0, -1, 4'h0, 32'h0,
                32'h0, 1'b1, 1'b0, 1, 0);
      // LW timeout after 4 BUSY cycles, then a normal SW
      do_access(1'b0, 3'b010, 32'h20, 32'h0, 32'h55555555, -1, 4'b1111, 32'h0,
                32'h0, 1'b0, 1'b1, 5, 4);
      do_access(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1, 4'b1111, 32'hCAFEF00D,
                32'h0, 1'b0, 1'b0, 3, 2);
      // Reset asserted mid-BUSY
      req_valid = 1'b1;
      req_write = 1'b0;
      req_type  = 3'b010;
      req_addr  = 32'h8;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      check_val("busy_bus_req", {31'h0, bus_req}, 32'h1);
      RESET = 1'b0;
      #1;
      check_val("rstmid_bus_req", {31'h0, bus_req}, 32'h0);
      check_val("rstmid_stall", {31'h0, stall}, 32'h0);
      check_val("rstmid_bus_addr", bus_addr, 32'h0);
      req_valid = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      do_access(1'b0, 3'b010, 32'h8, 32'h0, 32'h12345678, 1, 4'b1111, 32'h0,
                32'h12345678, 1'b0, 1'b0, 3, 2);
      check_val("sb_left", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
